// File: rtl/rv_pkg.sv
// Shared core definitions: fetch FSM states, reset vector, alignment helper,
// and the opcode/immediate enums used by the controller.
package rv_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] IALIGN_MASK   = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD
    } fetch_state_e;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_e;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_sel_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    // No C extension, so every fetch target is a 32-bit word boundary.
    function automatic logic [31:0] ialign(input logic [31:0] addr);
        return addr & IALIGN_MASK;
    endfunction

endpackage

// File: rtl/inst_fetch_pc_next.sv
// Next-PC selection: sequential pc+4 or the aligned ALU jump/branch target.
// Kept combinational so a pipelined fetch can reuse it unchanged.
module pc_next
    import rv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        pc_sel,
    input  logic [31:0] alu_data,
    output logic [31:0] pc_four,
    output logic [31:0] next_pc
);

    assign pc_four = pc + 32'd4;
    assign next_pc = pc_sel ? ialign(alu_data) : pc_four;

endmodule

// File: rtl/inst_fetch.sv
// Single-outstanding instruction fetch: owns the PC, talks req/ack/rvalid
// to imem and holds the fetched word for the decoder until retired.
module inst_fetch
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
    parameter int          XLEN      = XLEN_DEF
) (
    input  logic            i_clk,
    input  logic            i_reset,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ack,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic [XLEN-1:0] o_inst,
    output logic            o_inst_vld,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_four,
    input  logic            i_inst_rdy,
    input  logic            i_pc_sel,
    input  logic [XLEN-1:0] i_alu_data,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_flush_pc,
    output logic [XLEN-1:0] o_retire_cnt
);

    fetch_state_e    state;
    fetch_state_e    state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] pc_four;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] retire_cnt;
    logic            kill;
    logic            kill_nxt;
    logic            load_inst;
    logic            retire;

    pc_next u_pc_next (
        .pc       (pc),
        .pc_sel   (i_pc_sel),
        .alu_data (i_alu_data),
        .pc_four  (pc_four),
        .next_pc  (target)
    );

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        kill_nxt  = kill;
        load_inst = 1'b0;
        retire    = 1'b0;
        unique case (state)
            FETCH: begin
                if (i_imem_ack) begin
                    state_nxt = WAIT;
                    kill_nxt  = i_flush;
                end
            end
            WAIT: begin
                if (i_imem_rvalid) begin
                    kill_nxt  = 1'b0;
                    load_inst = !kill && !i_flush;
                    state_nxt = load_inst ? HOLD : FETCH;
                end else if (i_flush) begin
                    // The in-flight word still has to drain; mark it stale.
                    kill_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (i_flush) begin
                    state_nxt = FETCH;
                end else if (i_inst_rdy) begin
                    state_nxt = FETCH;
                    pc_nxt    = target;
                    retire    = 1'b1;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
        if (i_flush) begin
            pc_nxt = ialign(i_flush_pc);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= FETCH;
            pc         <= RESET_VEC;
            kill       <= 1'b0;
            inst       <= '0;
            retire_cnt <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            kill  <= kill_nxt;
            if (load_inst) begin
                inst <= i_imem_rdata;
            end
            if (retire) begin
                retire_cnt <= retire_cnt + 1'b1;
            end
        end
    end

    // Gated by reset so the request drops the instant reset asserts.
    assign o_imem_req   = i_reset && (state == FETCH);
    assign o_imem_addr  = pc;
    assign o_inst       = inst;
    assign o_inst_vld   = (state == HOLD);
    assign o_pc         = pc;
    assign o_pc_four    = pc_four;
    assign o_retire_cnt = retire_cnt;

    rvalid_only_in_wait: assert property (
        @(posedge i_clk) disable iff (!i_reset)
        i_imem_rvalid |-> (state == WAIT)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: behavioural imem slave plus a PC/retire reference
// model, directed scenarios followed by randomized traffic.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] inst;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] pc_four;
    logic        rdy;
    logic        pc_sel;
    logic [31:0] alu;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] rcnt;

    int checks = 0;
    int errors = 0;

    bit          pending;
    int          lat_left;
    logic [31:0] paddr;
    int          ack_pct;
    int          lat_min;
    int          lat_max;

    logic [31:0] pc_m;
    logic [31:0] cnt_m;
    bit          flushed;
    int          idle;

    logic [31:0] hi;
    logic [31:0] hp;
    logic [31:0] hc;

    always #5 clk = ~clk;

    inst_fetch dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .o_imem_req    (req),
        .o_imem_addr   (addr),
        .i_imem_ack    (ack),
        .i_imem_rvalid (rvalid),
        .i_imem_rdata  (rdata),
        .o_inst        (inst),
        .o_inst_vld    (vld),
        .o_pc          (pc),
        .o_pc_four     (pc_four),
        .i_inst_rdy    (rdy),
        .i_pc_sel      (pc_sel),
        .i_alu_data    (alu),
        .i_flush       (flush),
        .i_flush_pc    (flush_pc),
        .o_retire_cnt  (rcnt)
    );

    // Bijective scramble: each word address holds a distinct instruction.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    task automatic observe();
        chk("retire_cnt", rcnt, cnt_m);
        if (flushed) begin
            chk("vld_after_flush", 32'(vld), 32'd0);
            idle = 0;
        end
        if (vld) begin
            chk("pc", pc, pc_m);
            chk("pc_four", pc_four, pc_m + 32'd4);
            chk("inst", inst, mem(pc_m));
            chk("req_in_hold", 32'(req), 32'd0);
            idle = 0;
        end else begin
            chk("req_state", 32'(req), 32'(!pending));
            if (req) begin
                chk("addr", addr, pc_m);
            end
            idle++;
            if (idle > 40) begin
                chk("stall", 32'(idle), 32'd40);
                idle = 0;
            end
        end
    endtask

    task automatic cycle();
        bit ret;
        ack    = req && !pending && (int'($urandom_range(99)) < ack_pct);
        rvalid = pending && (lat_left == 0);
        rdata  = rvalid ? mem(paddr) : 32'hDEAD_BEEF;
        ret    = vld && rdy && !flush;
        @(posedge clk);
        if (flush) begin
            pc_m = flush_pc & ~32'h3;
        end else if (ret) begin
            cnt_m = cnt_m + 32'd1;
            pc_m  = pc_sel ? (alu & ~32'h3) : pc_m + 32'd4;
        end
        if (rvalid) begin
            pending = 1'b0;
        end else if (pending) begin
            lat_left--;
        end
        if (ack) begin
            pending  = 1'b1;
            paddr    = addr;
            lat_left = int'($urandom_range(lat_max, lat_min)) - 1;
        end
        flushed = flush;
        @(negedge clk);
        ack    = 1'b0;
        rvalid = 1'b0;
        observe();
    endtask

    function automatic bit hit(input int what);
        case (what)
            0:       return vld;
            1:       return req && !pending;
            default: return pending && lat_left > 0;
        endcase
    endfunction

    task automatic run_until(input int what);
        for (int n = 0; n < 60 && !hit(what); n++) begin
            cycle();
        end
        chk("reach", 32'(hit(what)), 32'd1);
    endtask

    task automatic retire_one();
        rdy = 1'b1;
        cycle();
        rdy = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        ack      = 1'b0;
        rvalid   = 1'b0;
        rdata    = '0;
        rdy      = 1'b0;
        pc_sel   = 1'b0;
        alu      = '0;
        flush    = 1'b0;
        flush_pc = '0;
        pending  = 1'b0;
        lat_left = 0;
        paddr    = '0;
        ack_pct  = 100;
        lat_min  = 1;
        lat_max  = 1;
        pc_m     = 32'h0;
        cnt_m    = 32'h0;
        flushed  = 1'b0;
        idle     = 0;

        repeat (3) @(negedge clk);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_vld", 32'(vld), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_cnt", rcnt, 32'd0);
        chk("rst_pc", pc, 32'd0);

        rst_n = 1'b1;
        #1;
        chk("first_req", 32'(req), 32'd1);
        chk("first_addr", addr, 32'h0);
        cycle();
        chk("vld_c2", 32'(vld), 32'd0);
        chk("wait_req", 32'(req), 32'd0);
        cycle();
        chk("vld_c3", 32'(vld), 32'd1);
        chk("pc_four0", pc_four, 32'h4);
        chk("inst0", inst, mem(32'h0));
        retire_one();
        chk("seq_req", 32'(req), 32'd1);
        chk("seq_addr", addr, 32'h4);
        chk("cnt1", rcnt, 32'd1);

        run_until(0);
        hi = inst;
        hp = pc;
        hc = rcnt;
        repeat (5) begin
            cycle();
            chk("hold_inst", inst, hi);
            chk("hold_pc", pc, hp);
            chk("hold_req", 32'(req), 32'd0);
            chk("hold_cnt", rcnt, hc);
        end

        pc_sel = 1'b1;
        alu    = 32'h0000_0103;
        retire_one();
        pc_sel = 1'b0;
        chk("jump_addr", addr, 32'h0000_0100);

        lat_min = 3;
        lat_max = 3;
        run_until(2);
        flush    = 1'b1;
        flush_pc = 32'h200;
        cycle();
        flush = 1'b0;
        chk("wflush_noreq", 32'(req), 32'd0);
        run_until(1);
        chk("wflush_addr", addr, 32'h200);
        run_until(0);
        chk("wflush_inst", inst, mem(32'h200));
        retire_one();

        lat_min = 2;
        lat_max = 2;
        run_until(1);
        flush    = 1'b1;
        flush_pc = 32'h200;
        cycle();
        flush = 1'b0;
        chk("fflush_pend", 32'(pending), 32'd1);
        chk("fflush_noreq", 32'(req), 32'd0);
        run_until(1);
        chk("fflush_addr", addr, 32'h200);
        run_until(0);
        chk("fflush_inst", inst, mem(32'h200));

        flush    = 1'b1;
        flush_pc = 32'hFFFF_FFFC;
        cycle();
        flush = 1'b0;
        run_until(0);
        chk("top_pc", pc, 32'hFFFF_FFFC);
        chk("top_pc_four", pc_four, 32'h0);
        retire_one();
        chk("wrap_req", 32'(req), 32'd1);
        chk("wrap_addr", addr, 32'h0);

        lat_min = 3;
        lat_max = 3;
        run_until(2);
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(req), 32'd0);
        chk("midrst_vld", 32'(vld), 32'd0);
        pending = 1'b0;
        pc_m    = 32'h0;
        cnt_m   = 32'h0;
        flushed = 1'b0;
        idle    = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rerst_req", 32'(req), 32'd1);
        chk("rerst_addr", addr, 32'h0);
        chk("rerst_cnt", rcnt, 32'd0);

        ack_pct = 60;
        lat_min = 1;
        lat_max = 3;
        repeat (3000) begin
            rdy      = int'($urandom_range(99)) < 70;
            pc_sel   = int'($urandom_range(99)) < 25;
            alu      = $urandom;
            flush    = int'($urandom_range(99)) < 5;
            flush_pc = $urandom;
            cycle();
        end
        flush = 1'b0;
        rdy   = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
